// File: rtl/frame_loader_pkg.sv
// frame_loader_pkg: shared frame geometry and loader state encoding
package frame_loader_pkg;
  localparam int ADDR_W = 15;
  localparam int NUM_PIXELS = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/frame_loader_pixel_unpacker.sv
// pixel_unpacker: byte-to-pixel shift register with handshake ready logic
module pixel_unpacker (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       run,
  input  logic       last,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       emit,
  output logic       pixel
);
  logic [7:0] sr;
  logic [3:0] bits_left;
  logic accept;
  assign emit = bits_left != 4'd0;
  assign pixel = sr[7];
  assign in_ready = run && (bits_left == 4'd0 || (bits_left == 4'd1 && !last));
  assign accept = in_valid && in_ready;
  always_ff @(posedge clock)
    if (reset || clear) begin
      sr <= '0;
      bits_left <= '0;
    end else if (accept) begin
      sr <= in_data;
      bits_left <= 4'd8;
    end else if (emit) begin
      sr <= {sr[6:0], 1'b0};
      bits_left <= bits_left - 4'd1;
    end
endmodule

// File: rtl/frame_loader.sv
// frame_loader: loads a packed 1-bit frame into frame RAM in raster order
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int ADDR_W = frame_loader_pkg::ADDR_W,
  parameter int NUM_PIXELS = frame_loader_pkg::NUM_PIXELS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy,
  output logic              done
);
  state_t state, state_next;
  logic [ADDR_W:0] cnt;
  logic clear, last, emit;
  assign clear = state == IDLE && start;
  assign last = cnt == (ADDR_W+1)'(NUM_PIXELS - 1);
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_next;
  always_comb
    state_next = state == IDLE ? (start ? RUN : IDLE) :
                 state == RUN  ? (emit && last ? DONE : RUN) : IDLE;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clock)
    if (reset || clear) cnt <= '0;
    else if (emit) cnt <= cnt + (ADDR_W+1)'(1);
  assign wr_en = emit;
  assign wr_addr = cnt[ADDR_W-1:0];
  pixel_unpacker u_unpacker (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .run(state == RUN),
    .last(last),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .emit(emit),
    .pixel(wr_data)
  );
endmodule

// File: doc/frame_loader.md
# frame_loader

Streams a new 1-bit image into the 32768×1 frame memory that feeds the morphological processing chain, replacing the ROM-only image with a loadable RAM. It accepts packed pixel bytes over a valid/ready handshake, unpacks them MSB-first, and drives one write per cycle in raster order from address 0 to 32767. It sits upstream of the frame RAM write port. The display side keeps reading through the existing address path, so a frame can be swapped while the display runs with the processing switches unchanged.

## Interface
Parameters:
- ADDR_W, 15, frame memory address width.
- NUM_PIXELS, 32768, pixels per frame; must equal 2**ADDR_W and be a multiple of 8.

Ports:
- clock  in  1  system clock; the single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to load a frame; sampled only in IDLE.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  eight pixels; bit 7 is the lowest address.
- in_ready  out  1  loader accepts in_data this cycle.
- wr_en  out  1  frame RAM write strobe.
- wr_addr  out  ADDR_W  frame RAM write address.
- wr_data  out  1  pixel value to write.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final pixel is written.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=0, wr_en=0. If start=1, go to RUN and clear the pixel counter and bits_left.
- RUN:
  - Byte accept happens when in_valid & in_ready.
  - in_ready = (bits_left == 0) || (bits_left == 1).
  - On accept, load the shift register with in_data and set bits_left=8.
  - Each cycle with bits_left>0:
    - wr_en=1, wr_data=sr[7], wr_addr=pixel counter.
    - Then shift sr left, decrement bits_left, increment the counter.
  - When bits_left==1 and a new byte is accepted in the same cycle, the last bit is emitted and the new byte is loaded, so no bubble occurs.
- The counter is ADDR_W+1 bits wide. When the pixel at address NUM_PIXELS-1 is emitted, go to DONE; any byte still offered is not accepted (in_ready=0).
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- start outside IDLE is ignored. in_valid outside RUN is ignored and in_ready stays 0.
- Gaps in in_valid produce gaps in wr_en. No bit is dropped or repeated, and wr_addr is strictly consecutive across gaps.
- reset, at any time including mid-frame: the next cycle is IDLE with all outputs at reset values. Already-written RAM contents are left as they are; a new start restarts at address 0.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
- start sampled at edge t: busy=1 and in_ready=1 from cycle t+1.
- Byte accepted at edge k: wr_en=1 in cycles k+1..k+8, carrying bits 7..0 at consecutive addresses.
- in_ready is high again in cycle k+8.
- Minimum frame time, start to done: 1 + 32768 + 1 cycles when in_valid is held high.
- The RAM samples wr_en/wr_addr/wr_data on the same clock edge, so there are no combinational paths from in_valid to wr_*.

## Structure
- Shared package holds ADDR_W, NUM_PIXELS, and the state enum {IDLE, RUN, DONE}. The existing address-generation and display logic import the same constants.
- One natural sub-module: pixel_unpacker, which holds the 8-bit shift register, bits_left and the ready logic.
- frame_loader keeps the FSM, the address counter and the done/busy logic.

## Test plan
- Reset check: assert reset for 3 cycles during RUN -> every output is 0 the next cycle, state IDLE, no wr_en afterwards.
- Full frame: start, then 4096 bytes of 0xA5 with in_valid held high.
  - wr_data repeats the pattern 1,0,1,0,0,1,0,1.
  - wr_addr runs 0..32767 with no gaps.
  - done pulses exactly once at cycle 32770 after start.
- Backpressure/gaps: in_valid toggling randomly with bytes 0x00..0xFF counting.
  - Captured RAM contents match the unpacked stream.
  - wr_addr is consecutive and no write occurs while bits_left==0.
- start ignored: pulse start at addr 500 mid-frame -> no counter reset, and the frame completes normally.
- Reset mid-frame at addr 100, then new start -> the first write after the new start is at addr 0 and carries bit 7 of the first new byte.
- Idle inputs: in_valid=1 with no start for 50 cycles -> in_ready=0 and wr_en=0 throughout; a byte offered in the cycle after done is not accepted.
